// File: rtl/deg_bcd_serial.sv
// deg_bcd_serial: serial signed fixed-point degrees to sign + 3 BCD integer digits + fractional BCD digits.
// The integer part uses double-dabble (one bit per cycle); the fraction uses repeated x10 (one digit per cycle).
module deg_bcd_serial #(
    parameter int W           = 36,
    parameter int FRAC        = 18,
    parameter int FRAC_DIGITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [W-1:0]             deg_in,
    output logic                     busy,
    output logic                     valid,
    output logic                     sign_out,
    output logic [11:0]              bcd_int,
    output logic [4*FRAC_DIGITS-1:0] bcd_frac,
    output logic                     ovf
);
    localparam int IW = W - FRAC;
    localparam int FW = 4 * FRAC_DIGITS;

    typedef enum logic [1:0] {IDLE, LOAD, ISHIFT, FSHIFT} state_t;

    state_t           state;
    logic [W-1:0]     deg;
    logic             sgn;
    logic             ovf_int;
    logic [9:0]       ip;
    logic [FRAC-1:0]  fp;
    logic [11:0]      bcd;
    logic [FW-1:0]    fr;
    logic [3:0]       cnt;

    logic [W-1:0]     mag;
    logic [IW-1:0]    ipw;
    logic             big;
    logic [21:0]      sh;
    logic [FRAC+3:0]  f;
    logic [FW+3:0]    frw;
    logic [FW-1:0]    fr_next;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Two's complement negate in W bits: the most negative input maps to 2^(W-1).
    assign mag     = sgn ? (~deg + 1'b1) : deg;
    assign ipw     = mag[W-1:FRAC];
    assign big     = ipw > IW'(999);
    assign sh      = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0]), ip} << 1;
    assign f       = ({4'b0, fp} << 3) + ({4'b0, fp} << 1);
    assign frw     = {fr, f[FRAC+3:FRAC]};
    assign fr_next = frw[FW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            deg      <= '0;
            sgn      <= 1'b0;
            ovf_int  <= 1'b0;
            ip       <= '0;
            fp       <= '0;
            bcd      <= '0;
            fr       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            sign_out <= 1'b0;
            bcd_int  <= '0;
            bcd_frac <= '0;
            ovf      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    deg   <= deg_in;
                    sgn   <= deg_in[W-1];
                    busy  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    ip      <= big ? 10'd999 : ipw[9:0];
                    ovf_int <= big;
                    fp      <= mag[FRAC-1:0];
                    bcd     <= '0;
                    fr      <= '0;
                    cnt     <= '0;
                    state   <= ISHIFT;
                end
                ISHIFT: begin
                    {bcd, ip} <= sh;
                    cnt       <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
                    state     <= (cnt == 4'd9) ? FSHIFT : ISHIFT;
                end
                FSHIFT: begin
                    fp  <= f[FRAC-1:0];
                    fr  <= fr_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(FRAC_DIGITS - 1)) begin
                        bcd_int  <= bcd;
                        bcd_frac <= ovf_int ? {FRAC_DIGITS{4'h9}} : fr_next;
                        ovf      <= ovf_int;
                        sign_out <= sgn && (ovf_int || bcd != 12'd0 || fr_next != '0);
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
